// File: rtl/alu_op_sequencer_if.sv
// Interface bundling the sequencer's command, bus, ALU and result signals.
//   master: upstream control / bus / ALU side (drives start, operands, ALU results, res_ready)
//   slave : the sequencer itself (drives ALU controls, result, flags, busy, res_valid)
interface alu_op_sequencer_if #(
  parameter int unsigned DW = 8
);
  logic          start;
  logic          m_in;
  logic [3:0]    s_in;
  logic [DW-1:0] bus_in;
  logic          bus_we;
  logic [DW-1:0] alu_t;
  logic          alu_cf;
  logic          alu_zf;
  logic          alu_m;
  logic [3:0]    alu_s;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          busy;
  logic [DW-1:0] res;
  logic          cf;
  logic          zf;
  logic          res_valid;
  logic          res_ready;

  modport master (
    output start, m_in, s_in, bus_in, bus_we, alu_t, alu_cf, alu_zf, res_ready,
    input  alu_m, alu_s, alu_a, alu_b, busy, res, cf, zf, res_valid
  );

  modport slave (
    input  start, m_in, s_in, bus_in, bus_we, alu_t, alu_cf, alu_zf, res_ready,
    output alu_m, alu_s, alu_a, alu_b, busy, res, cf, zf, res_valid
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Operand/command sequencer in front of the 8-bit combinational ALU.
// Latches an op (m,s), collects operand A then B from the shared bus, holds the ALU inputs
// for one EXEC cycle, registers result and CF/ZF, then offers them under valid/ready.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   sif : alu_op_sequencer_if.slave (command, bus, ALU inputs/outputs, result handshake)
module alu_op_sequencer #(
  parameter int unsigned DW        = 8,
  parameter bit          FLAG_HOLD = 1'b1
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave sif
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoadA = 3'd1;
  localparam logic [2:0] StLoadB = 3'd2;
  localparam logic [2:0] StExec  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [3:0] SelAdd = 4'b1001;
  localparam logic [3:0] SelSub = 4'b0110;

  logic [2:0]    state_q, state_d;
  logic          alu_m_q;
  logic [3:0]    alu_s_q;
  logic [DW-1:0] alu_a_q, alu_b_q, res_q;
  logic          cf_q, zf_q;
  logic          flags_we;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sif.start)     state_d = StLoadA;
      StLoadA: if (sif.bus_we)    state_d = StLoadB;
      StLoadB: if (sif.bus_we)    state_d = StExec;
      StExec:                     state_d = StDone;
      StDone:  if (sif.res_ready) state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  // With FLAG_HOLD only arithmetic ops (ADD/SUB in arithmetic mode) touch CF/ZF.
  always_comb begin
    flags_we = 1'b0;
    if (state_q == StExec) begin
      flags_we = !FLAG_HOLD || (alu_m_q && (alu_s_q == SelAdd || alu_s_q == SelSub));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      alu_m_q <= 1'b0;
      alu_s_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && sif.start) begin
        alu_m_q <= sif.m_in;
        alu_s_q <= sif.s_in;
      end
      if (state_q == StLoadA && sif.bus_we) alu_a_q <= sif.bus_in;
      if (state_q == StLoadB && sif.bus_we) alu_b_q <= sif.bus_in;
      if (state_q == StExec) res_q <= sif.alu_t;
      if (flags_we) begin
        cf_q <= sif.alu_cf;
        zf_q <= sif.alu_zf;
      end
    end
  end

  assign sif.alu_m     = alu_m_q;
  assign sif.alu_s     = alu_s_q;
  assign sif.alu_a     = alu_a_q;
  assign sif.alu_b     = alu_b_q;
  assign sif.res       = res_q;
  assign sif.cf        = cf_q;
  assign sif.zf        = zf_q;
  assign sif.busy      = (state_q != StIdle);
  // DONE is the only state holding a presentable result.
  assign sif.res_valid = (state_q == StDone);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer: one instance with FLAG_HOLD=1 and a shadow
// instance with FLAG_HOLD=0 fed the same stimulus, each driving a small ALU model.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_op_sequencer_if #(.DW(8)) if0 ();
  alu_op_sequencer_if #(.DW(8)) if1 ();

  alu_op_sequencer #(.DW(8), .FLAG_HOLD(1'b1)) u_dut_hold (
    .clk (clk),
    .rst (rst),
    .sif (if0)
  );

  alu_op_sequencer #(.DW(8), .FLAG_HOLD(1'b0)) u_dut_nohold (
    .clk (clk),
    .rst (rst),
    .sif (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: {cf, zf, t}. ADD a+b, SUB b-a (cf=borrow), AND, MOV B; others return 0.
  function automatic logic [9:0] alu_model(input logic m, input logic [3:0] s,
                                           input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] t;
    logic       c;
    t = 8'h00;
    c = 1'b0;
    w = 9'h000;
    if (m && s == 4'b1001) begin
      w = {1'b0, a} + {1'b0, b};
      t = w[7:0];
      c = w[8];
    end else if (m && s == 4'b0110) begin
      t = b - a;
      c = (a > b);
    end else if (m && s == 4'b1011) begin
      t = a & b;
    end else if (!m && s == 4'b1010) begin
      t = b;
    end
    return {c, (t == 8'h00), t};
  endfunction

  assign {if0.alu_cf, if0.alu_zf, if0.alu_t} = alu_model(if0.alu_m, if0.alu_s, if0.alu_a, if0.alu_b);
  assign {if1.alu_cf, if1.alu_zf, if1.alu_t} = alu_model(if1.alu_m, if1.alu_s, if1.alu_a, if1.alu_b);

  assign if1.start     = if0.start;
  assign if1.m_in      = if0.m_in;
  assign if1.s_in      = if0.s_in;
  assign if1.bus_in    = if0.bus_in;
  assign if1.bus_we    = if0.bus_we;
  assign if1.res_ready = if0.res_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one op from IDLE up to the edge that enters DONE. Inputs change #1 after edges.
  task automatic do_op(input logic m, input logic [3:0] s, input logic [7:0] a,
                       input logic [7:0] b, input int gap_a, input int gap_b,
                       input bit exec_we);
    if0.start = 1'b1;
    if0.m_in  = m;
    if0.s_in  = s;
    tick();
    if0.start = 1'b0;
    repeat (gap_a) tick();
    if0.bus_we = 1'b1;
    if0.bus_in = a;
    tick();
    if0.bus_we = 1'b0;
    repeat (gap_b) tick();
    if0.bus_we = 1'b1;
    if0.bus_in = b;
    tick();
    if0.bus_we = 1'b0;
    check("exec_not_valid", {31'd0, if0.res_valid}, 32'd0);
    if (exec_we) begin
      if0.bus_we = 1'b1;
      if0.bus_in = 8'h77;
    end
    tick();
    if0.bus_we = 1'b0;
    check("res_valid_latency", {31'd0, if0.res_valid}, 32'd1);
    check("operand_a", {24'd0, if0.alu_a}, {24'd0, a});
    check("operand_b", {24'd0, if0.alu_b}, {24'd0, b});
  endtask

  task automatic handshake();
    if0.res_ready = 1'b1;
    tick();
    if0.res_ready = 1'b0;
    check("hs_valid_low", {31'd0, if0.res_valid}, 32'd0);
    check("hs_idle", {31'd0, if0.busy}, 32'd0);
  endtask

  task automatic check_flags(input string tag, input logic [7:0] res, input logic cf0,
                             input logic zf0, input logic cf1, input logic zf1);
    check({tag, "_res"}, {24'd0, if0.res}, {24'd0, res});
    check({tag, "_cf_hold"}, {31'd0, if0.cf}, {31'd0, cf0});
    check({tag, "_zf_hold"}, {31'd0, if0.zf}, {31'd0, zf0});
    check({tag, "_res_nohold"}, {24'd0, if1.res}, {24'd0, res});
    check({tag, "_cf_nohold"}, {31'd0, if1.cf}, {31'd0, cf1});
    check({tag, "_zf_nohold"}, {31'd0, if1.zf}, {31'd0, zf1});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, if0.busy}, 32'd0);
    check({tag, "_valid"}, {31'd0, if0.res_valid}, 32'd0);
    check({tag, "_res"}, {24'd0, if0.res}, 32'd0);
    check({tag, "_flags"}, {30'd0, if0.cf, if0.zf}, 32'd0);
    check({tag, "_ops"}, {if0.alu_a, if0.alu_b, 11'd0, if0.alu_m, if0.alu_s}, 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    if0.start     = 1'b0;
    if0.m_in      = 1'b0;
    if0.s_in      = 4'h0;
    if0.bus_in    = 8'h00;
    if0.bus_we    = 1'b0;
    if0.res_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // ADD 0x80+0x80, minimum latency; continuous bus_we proves A-then-B ordering.
    do_op(1'b1, 4'b1001, 8'h80, 8'h80, 0, 0, 1'b0);
    check("add_busy", {31'd0, if0.busy}, 32'd1);
    check_flags("add80", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    handshake();

    // SUB computes B-A.
    do_op(1'b1, 4'b0110, 8'h05, 8'h03, 0, 0, 1'b0);
    check_flags("sub53", 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
    handshake();
    do_op(1'b1, 4'b0110, 8'h03, 8'h03, 0, 0, 1'b0);
    check_flags("sub33", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    handshake();

    // Flag hold: ADD sets cf/zf, AND must not touch them when FLAG_HOLD=1.
    do_op(1'b1, 4'b1001, 8'hFF, 8'h01, 0, 0, 1'b0);
    check_flags("addff", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    handshake();
    do_op(1'b1, 4'b1011, 8'hF0, 8'h3C, 0, 0, 1'b0);
    check_flags("and", 8'h30, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure in DONE with a stray start.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        if0.start = 1'b1;
        if0.m_in  = 1'b0;
        if0.s_in  = 4'b0000;
      end
      tick();
      if0.start = 1'b0;
      check("bp_valid", {31'd0, if0.res_valid}, 32'd1);
      check("bp_busy", {31'd0, if0.busy}, 32'd1);
      check("bp_res", {24'd0, if0.res}, 32'h30);
    end
    check("bp_op_kept", {27'd0, if0.alu_m, if0.alu_s}, {27'd0, 1'b1, 4'b1011});
    handshake();
    check("hs_res_held", {24'd0, if0.res}, 32'h30);

    // bus_we in IDLE must be ignored.
    if0.bus_we = 1'b1;
    if0.bus_in = 8'hAA;
    tick();
    if0.bus_we = 1'b0;
    check("idle_we_ignored", {24'd0, if0.alu_a}, 32'hF0);
    check("idle_stays", {31'd0, if0.busy}, 32'd0);

    // MOV with gaps before A and B, plus a bus_we pulse during EXEC.
    do_op(1'b0, 4'b1010, 8'h11, 8'h5A, 3, 2, 1'b1);
    check_flags("mov", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    handshake();

    // Asynchronous reset while in LOAD_B.
    if0.start = 1'b1;
    if0.m_in  = 1'b1;
    if0.s_in  = 4'b1001;
    tick();
    if0.start  = 1'b0;
    if0.bus_we = 1'b1;
    if0.bus_in = 8'h99;
    tick();
    if0.bus_we = 1'b0;
    check("midop_busy", {31'd0, if0.busy}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", {31'd0, if0.busy}, 32'd0);

    do_op(1'b1, 4'b1001, 8'h12, 8'h34, 0, 0, 1'b0);
    check_flags("post_rst_add", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
